// File: rtl/locked_reg_pkg.sv
// Shared types and defaults for the locked register access arbiter.
// Optional build macro DEBUG_OVERRIDE_EN is consumed by locked_reg_access_arbiter.
package locked_reg_pkg;

    localparam int DEF_NUM_REGS = 4;
    localparam int DEF_DATA_W   = 16;

    // Transaction sequencing states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_COMMIT = 2'd2,
        S_RESP   = 2'd3
    } arb_state_e;

    // Identity of the requester owning the current transaction
    typedef enum logic {
        REQ_HOST  = 1'b0,
        REQ_DEBUG = 1'b1
    } req_id_e;

    // The requester that gets priority after 'id' has been served
    function automatic req_id_e other_requester(input req_id_e id);
        if (id == REQ_HOST) begin
            return REQ_DEBUG;
        end else begin
            return REQ_HOST;
        end
    endfunction

endpackage

// File: rtl/locked_reg_access_arbiter_bank.sv
// Register file with one sticky lock bit per register.
// One write port (data write plus optional lock set) and one combinational read port.
module locked_reg_bank
    import locked_reg_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_we,
    input  logic                        i_lock_set,
    input  logic [$clog2(NUM_REGS)-1:0] i_waddr,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [$clog2(NUM_REGS)-1:0] i_raddr,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [NUM_REGS-1:0]         o_lock_vec
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_lock;

    // Storage update: reset clears data and locks; locks can only ever be set
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_lock <= '0;
        end else begin
            if (i_we) begin
                r_regs[i_waddr] <= i_wdata;
            end
            if (i_lock_set) begin
                r_lock[i_waddr] <= 1'b1;
            end
        end
    end

    assign o_rdata    = r_regs[i_raddr];
    assign o_lock_vec = r_lock;

endmodule

// File: rtl/locked_reg_access_arbiter.sv
// Round-robin arbiter between a host and a debug writer in front of a lockable
// register bank. Each transaction runs IDLE -> GRANT -> COMMIT -> RESP.
// Build macro DEBUG_OVERRIDE_EN: authorised debug writes ignore register locks.
module locked_reg_access_arbiter
    import locked_reg_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        h_req,
    input  logic [$clog2(NUM_REGS)-1:0] h_addr,
    input  logic [DATA_W-1:0]           h_wdata,
    input  logic                        h_lock,
    output logic                        h_ack,
    output logic                        h_err,
    input  logic                        d_req,
    input  logic [$clog2(NUM_REGS)-1:0] d_addr,
    input  logic [DATA_W-1:0]           d_wdata,
    output logic                        d_ack,
    output logic                        d_err,
    input  logic                        trusted,
    input  logic                        debug_mode,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    output logic [NUM_REGS-1:0]         lock_vec
);

    localparam int AW = $clog2(NUM_REGS);

    localparam logic [1:0] ST_IDLE   = S_IDLE;
    localparam logic [1:0] ST_GRANT  = S_GRANT;
    localparam logic [1:0] ST_COMMIT = S_COMMIT;
    localparam logic [1:0] ST_RESP   = S_RESP;

    logic [1:0]          r_state;
    req_id_e             r_id;
    req_id_e             r_rr_prio;
    logic [AW-1:0]       r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_lock;
    logic                r_perm;
    logic                r_h_ack;
    logic                r_h_err;
    logic                r_d_ack;
    logic                r_d_err;

    logic                w_grant_host;
    logic                w_commit_ok;
    logic                w_we;
    logic                w_lock_set;
    logic                w_granted_req;
    logic [NUM_REGS-1:0] w_lock_vec;

    // Host wins when alone or when it holds the round-robin priority
    assign w_grant_host = h_req & (~d_req | (r_rr_prio == REQ_HOST));

    // Final write decision, using trusted/debug_mode as seen in COMMIT
    always_comb begin
        w_commit_ok = 1'b0;
        if (r_id == REQ_HOST) begin
            w_commit_ok = r_perm;
        end else begin
`ifdef DEBUG_OVERRIDE_EN
            w_commit_ok = trusted & debug_mode;
`else
            w_commit_ok = r_perm & trusted & debug_mode;
`endif
        end
    end

    assign w_we          = (r_state == ST_COMMIT) & w_commit_ok;
    assign w_lock_set    = w_we & (r_id == REQ_HOST) & r_lock;
    assign w_granted_req = (r_id == REQ_HOST) ? h_req : d_req;

    // Transaction sequencer, request latch and registered completion flags
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_id      <= REQ_HOST;
            r_rr_prio <= REQ_HOST;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_lock    <= 1'b0;
            r_perm    <= 1'b0;
            r_h_ack   <= 1'b0;
            r_h_err   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
        end else begin
            r_h_ack <= 1'b0;
            r_h_err <= 1'b0;
            r_d_ack <= 1'b0;
            r_d_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_host) begin
                        r_id      <= REQ_HOST;
                        r_rr_prio <= other_requester(REQ_HOST);
                        r_addr    <= h_addr;
                        r_wdata   <= h_wdata;
                        r_lock    <= h_lock;
                        r_state   <= ST_GRANT;
                    end else if (d_req) begin
                        r_id      <= REQ_DEBUG;
                        r_rr_prio <= other_requester(REQ_DEBUG);
                        r_addr    <= d_addr;
                        r_wdata   <= d_wdata;
                        r_lock    <= 1'b0;
                        r_state   <= ST_GRANT;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    r_perm  <= ~w_lock_vec[r_addr];
                    r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (r_id == REQ_HOST) begin
                        r_h_ack <= 1'b1;
                        r_h_err <= ~w_commit_ok;
                    end else begin
                        r_d_ack <= 1'b1;
                        r_d_err <= ~w_commit_ok;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (!w_granted_req) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    locked_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_bank (
        .i_clk      (Clk),
        .i_rst      (Reset),
        .i_we       (w_we),
        .i_lock_set (w_lock_set),
        .i_waddr    (r_addr),
        .i_wdata    (r_wdata),
        .i_raddr    (rd_addr),
        .o_rdata    (rd_data),
        .o_lock_vec (w_lock_vec)
    );

    assign lock_vec = w_lock_vec;
    assign h_ack    = r_h_ack;
    assign h_err    = r_h_err;
    assign d_ack    = r_d_ack;
    assign d_err    = r_d_err;

endmodule

// File: tb/tb_locked_reg_access_arbiter.sv
// Self-checking bench for locked_reg_access_arbiter (NUM_REGS=4, DATA_W=16).
// Expected results come from a register/lock model kept in plain arrays.
module tb_locked_reg_access_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        h_req = 1'b0;
    logic [1:0]  h_addr = 2'd0;
    logic [15:0] h_wdata = 16'd0;
    logic        h_lock = 1'b0;
    logic        h_ack, h_err;
    logic        d_req = 1'b0;
    logic [1:0]  d_addr = 2'd0;
    logic [15:0] d_wdata = 16'd0;
    logic        d_ack, d_err;
    logic        trusted = 1'b0;
    logic        debug_mode = 1'b0;
    logic [1:0]  rd_addr = 2'd0;
    logic [15:0] rd_data;
    logic [3:0]  lock_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: register contents, lock bits, who was served last
    logic [15:0] m_reg [4];
    bit          m_lock [4];
    bit          m_last_dbg;

    locked_reg_access_arbiter #(.NUM_REGS(4), .DATA_W(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .h_req(h_req), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
        .h_ack(h_ack), .h_err(h_err),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err),
        .trusted(trusted), .debug_mode(debug_mode),
        .rd_addr(rd_addr), .rd_data(rd_data), .lock_vec(lock_vec)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] model_lock_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_lock[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin m_reg[i] = 16'd0; m_lock[i] = 1'b0; end
        m_last_dbg = 1'b1;
    endfunction

    // apply one served request to the model, returning the expected err flag
    function automatic bit model_apply(input bit is_dbg, input logic [1:0] a, input logic [15:0] d,
                                       input bit lk, input bit tr, input bit dm);
        bit ok;
        if (!is_dbg) ok = !m_lock[a];
`ifdef DEBUG_OVERRIDE_EN
        else ok = tr && dm;
`else
        else ok = tr && dm && !m_lock[a];
`endif
        if (ok) begin
            m_reg[a] = d;
            if (!is_dbg && lk) m_lock[a] = 1'b1;
        end
        m_last_dbg = is_dbg;
        return !ok;
    endfunction

    // drive one lone request; scramble the requester's fields after the IDLE sample
    task automatic run_txn(input bit is_dbg, input logic [1:0] a, input logic [15:0] d, input bit lk,
                           input bit tr, input bit dm, input int drop_tr_at,
                           output bit got_ack, output bit got_err, output int lat,
                           output bit other_ack, output bit ack_stuck);
        got_ack = 1'b0; got_err = 1'b0; lat = 0; other_ack = 1'b0;
        trusted = tr; debug_mode = dm;
        if (is_dbg) begin d_req = 1'b1; d_addr = a; d_wdata = d; end
        else begin h_req = 1'b1; h_addr = a; h_wdata = d; h_lock = lk; end
        for (int k = 1; k <= 12; k++) begin
            @(posedge Clk); #1;
            if (k == 1) begin
                h_addr = 2'($urandom); h_wdata = 16'($urandom); h_lock = 1'($urandom);
                d_addr = 2'($urandom); d_wdata = 16'($urandom);
            end
            if (k == drop_tr_at) trusted = 1'b0;
            if (is_dbg ? d_ack : h_ack) begin
                got_ack = 1'b1; got_err = is_dbg ? d_err : h_err; lat = k;
                other_ack = is_dbg ? h_ack : d_ack;
                break;
            end
        end
        h_req = 1'b0; d_req = 1'b0;
        @(posedge Clk); #1;
        ack_stuck = h_ack | d_ack;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1; Reset = 1'b0;
        model_reset();
        n_cmp++; if ({h_ack, h_err, d_ack, d_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b want=0000", {h_ack, h_err, d_ack, d_err}); end
        n_cmp++; if (lock_vec !== 4'b0000) begin n_fail++; $display("FAIL reset_lock got=%b want=0000", lock_vec); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i); #1;
            n_cmp++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_reg%0d got=%h want=0000", i, rd_data); end
        end
    endtask

    task automatic test_host_write();
        bit ack, err, oth, stuck; int lat; bit exp_err;
        exp_err = model_apply(1'b0, 2'd1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 2'd1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 0, ack, err, lat, oth, stuck);
        n_cmp++; if (!ack || lat != 3) begin n_fail++; $display("FAIL host_latency got ack=%0d lat=%0d want ack=1 lat=3", ack, lat); end
        n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL host_err got=%0d want=%0d", err, exp_err); end
        n_cmp++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL host_ack_pulse got=%0d want=0", stuck); end
        rd_addr = 2'd1; #1;
        n_cmp++; if (rd_data !== m_reg[1]) begin n_fail++; $display("FAIL host_data got=%h want=%h", rd_data, m_reg[1]); end
        n_cmp++; if (lock_vec !== model_lock_vec()) begin n_fail++; $display("FAIL host_lockvec got=%b want=%b", lock_vec, model_lock_vec()); end
    endtask

    task automatic test_lock();
        bit ack, err, oth, stuck; int lat; bit exp_err;
        exp_err = model_apply(1'b0, 2'd2, 16'h1234, 1'b1, 1'b0, 1'b0);
        run_txn(1'b0, 2'd2, 16'h1234, 1'b1, 1'b0, 1'b0, 0, ack, err, lat, oth, stuck);
        n_cmp++; if (!ack || err !== exp_err) begin n_fail++; $display("FAIL lock_first got ack=%0d err=%0d want ack=1 err=%0d", ack, err, exp_err); end
        exp_err = model_apply(1'b0, 2'd2, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 2'd2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0, ack, err, lat, oth, stuck);
        n_cmp++; if (!ack || err !== exp_err) begin n_fail++; $display("FAIL lock_deny got ack=%0d err=%0d want ack=1 err=%0d", ack, err, exp_err); end
        rd_addr = 2'd2; #1;
        n_cmp++; if (rd_data !== m_reg[2]) begin n_fail++; $display("FAIL lock_data got=%h want=%h", rd_data, m_reg[2]); end
        n_cmp++; if (lock_vec !== model_lock_vec()) begin n_fail++; $display("FAIL lock_vec got=%b want=%b", lock_vec, model_lock_vec()); end
    endtask

    task automatic test_debug_locked();
        bit ack, err, oth, stuck; int lat; bit exp_err;
        exp_err = model_apply(1'b1, 2'd2, 16'hBEEF, 1'b0, 1'b1, 1'b1);
        run_txn(1'b1, 2'd2, 16'hBEEF, 1'b0, 1'b1, 1'b1, 0, ack, err, lat, oth, stuck);
        n_cmp++; if (!ack || lat != 3 || oth) begin n_fail++; $display("FAIL dbg_locked_ack got ack=%0d lat=%0d hack=%0d want 1/3/0", ack, lat, oth); end
        n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL dbg_locked_err got=%0d want=%0d", err, exp_err); end
        rd_addr = 2'd2; #1;
        n_cmp++; if (rd_data !== m_reg[2]) begin n_fail++; $display("FAIL dbg_locked_data got=%h want=%h", rd_data, m_reg[2]); end
        n_cmp++; if (lock_vec !== model_lock_vec()) begin n_fail++; $display("FAIL dbg_locked_vec got=%b want=%b", lock_vec, model_lock_vec()); end
    endtask

    task automatic test_debug_auth();
        bit ack, err, oth, stuck; int lat;
        // trusted low throughout
        void'(model_apply(1'b1, 2'd0, 16'h0BAD, 1'b0, 1'b0, 1'b1));
        run_txn(1'b1, 2'd0, 16'h0BAD, 1'b0, 1'b0, 1'b1, 0, ack, err, lat, oth, stuck);
        n_cmp++; if (!ack || err !== 1'b1) begin n_fail++; $display("FAIL dbg_untrusted got ack=%0d err=%0d want 1/1", ack, err); end
        // trusted high at the IDLE sample but dropped before COMMIT
        void'(model_apply(1'b1, 2'd0, 16'hC0DE, 1'b0, 1'b0, 1'b1));
        run_txn(1'b1, 2'd0, 16'hC0DE, 1'b0, 1'b1, 1'b1, 2, ack, err, lat, oth, stuck);
        n_cmp++; if (!ack || err !== 1'b1) begin n_fail++; $display("FAIL dbg_trust_drop got ack=%0d err=%0d want 1/1", ack, err); end
        rd_addr = 2'd0; #1;
        n_cmp++; if (rd_data !== m_reg[0]) begin n_fail++; $display("FAIL dbg_auth_data got=%h want=%h", rd_data, m_reg[0]); end
    endtask

    task automatic test_arbitration();
        for (int round = 0; round < 2; round++) begin
            bit first_dbg, exp_first_dbg, seen; int lat;
            logic [1:0] ha, da; logic [15:0] hd, dd; bit e1, e2;
            ha = 2'(round * 3); da = 2'(round + 1);
            hd = 16'($urandom); dd = 16'($urandom);
            exp_first_dbg = !m_last_dbg;
            trusted = 1'b1; debug_mode = 1'b1;
            h_req = 1'b1; h_addr = ha; h_wdata = hd; h_lock = 1'b0;
            d_req = 1'b1; d_addr = da; d_wdata = dd;
            seen = 1'b0; first_dbg = 1'b0; lat = 0;
            for (int k = 1; k <= 12 && !seen; k++) begin
                @(posedge Clk); #1;
                if (h_ack | d_ack) begin seen = 1'b1; first_dbg = d_ack; lat = k; end
            end
            n_cmp++; if (!seen || first_dbg !== exp_first_dbg || lat != 3) begin n_fail++; $display("FAIL arb_first_r%0d got seen=%0d dbg=%0d lat=%0d want dbg=%0d lat=3", round, seen, first_dbg, lat, exp_first_dbg); end
            if (exp_first_dbg) begin
                e1 = model_apply(1'b1, da, dd, 1'b0, 1'b1, 1'b1); e2 = model_apply(1'b0, ha, hd, 1'b0, 1'b0, 1'b0);
            end else begin
                e1 = model_apply(1'b0, ha, hd, 1'b0, 1'b0, 1'b0); e2 = model_apply(1'b1, da, dd, 1'b0, 1'b1, 1'b1);
            end
            n_cmp++; if ((first_dbg ? d_err : h_err) !== e1) begin n_fail++; $display("FAIL arb_err1_r%0d got=%0d want=%0d", round, first_dbg ? d_err : h_err, e1); end
            if (first_dbg) d_req = 1'b0; else h_req = 1'b0;
            seen = 1'b0;
            for (int k = 1; k <= 12 && !seen; k++) begin
                @(posedge Clk); #1;
                if (first_dbg ? h_ack : d_ack) seen = 1'b1;
            end
            n_cmp++; if (!seen || (first_dbg ? h_err : d_err) !== e2) begin n_fail++; $display("FAIL arb_second_r%0d got seen=%0d err=%0d want seen=1 err=%0d", round, seen, first_dbg ? h_err : d_err, e2); end
            h_req = 1'b0; d_req = 1'b0;
            @(posedge Clk); #1;
            rd_addr = ha; #1;
            n_cmp++; if (rd_data !== m_reg[ha]) begin n_fail++; $display("FAIL arb_hdata_r%0d got=%h want=%h", round, rd_data, m_reg[ha]); end
            rd_addr = da; #1;
            n_cmp++; if (rd_data !== m_reg[da]) begin n_fail++; $display("FAIL arb_ddata_r%0d got=%h want=%h", round, rd_data, m_reg[da]); end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        h_req = 1'b1; h_addr = 2'd3; h_wdata = 16'h5A5A; h_lock = 1'b1;
        @(posedge Clk); #1;          // request sampled, now in GRANT
        Reset = 1'b1; h_req = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (h_ack | d_ack) seen = 1'b1;
            @(posedge Clk); #1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack got=%0d want=0", seen); end
        n_cmp++; if (lock_vec !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_lock got=%b want=0000", lock_vec); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i); #1;
            n_cmp++; if (rd_data !== m_reg[i]) begin n_fail++; $display("FAIL rst_mid_reg%0d got=%h want=%h", i, rd_data, m_reg[i]); end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            bit is_dbg, lk, tr, dm, ack, err, oth, stuck, exp_err; int lat;
            logic [1:0] a; logic [15:0] d;
            is_dbg = 1'($urandom); a = 2'($urandom); d = 16'($urandom);
            lk = ($urandom_range(7, 0) == 0); tr = 1'($urandom); dm = 1'($urandom);
            exp_err = model_apply(is_dbg, a, d, lk, tr, dm);
            run_txn(is_dbg, a, d, lk, tr, dm, 0, ack, err, lat, oth, stuck);
            n_cmp++; if (!ack || lat != 3 || oth || stuck) begin n_fail++; $display("FAIL rnd%0d_hs got ack=%0d lat=%0d other=%0d stuck=%0d want 1/3/0/0", t, ack, lat, oth, stuck); end
            n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err dbg=%0d addr=%0d got=%0d want=%0d", t, is_dbg, a, err, exp_err); end
            rd_addr = a; #1;
            n_cmp++; if (rd_data !== m_reg[a]) begin n_fail++; $display("FAIL rnd%0d_data got=%h want=%h", t, rd_data, m_reg[a]); end
            n_cmp++; if (lock_vec !== model_lock_vec()) begin n_fail++; $display("FAIL rnd%0d_lock got=%b want=%b", t, lock_vec, model_lock_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_host_write();
        test_lock();
        test_debug_locked();
        test_debug_auth();
        test_arbitration();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/locked_reg_access_arbiter.md
LOCKED_REG_ACCESS_ARBITER -- requirements
Module: locked_reg_access_arbiter

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, the number of lockable registers (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 16, the register width.
REQ-003 SHALL have port Clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port h_req  input  1  host write request, held until h_ack.
REQ-006 SHALL have port h_addr  input  log2(NUM_REGS)  host target register.
REQ-007 SHALL have port h_wdata  input  DATA_W  host write data.
REQ-008 SHALL have port h_lock  input  1  host requests lock of target after the write.
REQ-009 SHALL have port h_ack / h_err  output  1 each  host completion pulse / denial flag.
REQ-010 SHALL have port d_req, d_addr, d_wdata  input  1 / log2(NUM_REGS) / DATA_W  debug write request, address, data.
REQ-011 SHALL have port d_ack / d_err  output  1 each  debug completion pulse / denial flag.
REQ-012 SHALL have port trusted, debug_mode  input  1 each  debug authorisation qualifiers.
REQ-013 SHALL have port rd_addr  input  log2(NUM_REGS)  read select; rd_data  output  DATA_W  combinational read of the selected register.
REQ-014 SHALL have port lock_vec  output  NUM_REGS  per-register lock status.

Function
REQ-015 SHALL implement FSM IDLE -> GRANT -> COMMIT -> RESP -> IDLE.
REQ-016 IDLE: if any req is high, SHALL latch the winner's addr/wdata/lock and requester ID, then go to GRANT.
REQ-017 Arbitration SHALL be round-robin: when both requests are high, the requester not granted last wins; after Reset the host wins first.
REQ-018 GRANT SHALL be a single fixed cycle that evaluates the permission; COMMIT SHALL sample trusted and debug_mode, then write or deny.
REQ-019 Host write SHALL succeed iff lock_vec[addr]==0; on success with h_lock=1, the register SHALL be written and its lock bit set in the same cycle.
REQ-020 Debug write SHALL be denied unless debug_mode & trusted in COMMIT; the debug requester SHALL never set or clear a lock.
REQ-021 A denied request SHALL leave the register and lock unchanged and assert err together with ack.
REQ-022 ack SHALL be a one-cycle pulse on RESP entry, 3 cycles after the request is sampled in IDLE; err is valid only with ack.
REQ-023 RESP SHALL hold until the granted req is low, then return to IDLE; no new grant is made while in RESP.
REQ-024 Lock bits SHALL be sticky; only Reset clears them.
REQ-025 Changes to req, addr or data by the granted requester after the IDLE sample SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE and clear all registers to 0, lock_vec to 0, ack/err to 0 and the round-robin pointer to host.
REQ-027 Reset asserted mid-transaction SHALL abort it with no ack and no register or lock update.

Configuration
REQ-028 With DEBUG_OVERRIDE_EN defined, an authorised debug write SHALL succeed even when the target is locked.
REQ-029 Without DEBUG_OVERRIDE_EN, an authorised debug write to a locked register SHALL be denied (err=1); authorised writes to unlocked registers succeed.

Structure
REQ-030 Package locked_reg_pkg SHALL hold the FSM state enum, the requester-ID typedef (HOST/DEBUG) and the DATA_W/NUM_REGS defaults.
REQ-031 The register-plus-lock storage SHALL be a sub-module, locked_reg_bank, with a write port (we, lock_set) and a read port.

Verification
REQ-032 Host write addr 1, data 0xA5A5, h_lock=0 -> h_ack 3 cycles later, h_err=0, rd_data[1]=0xA5A5, lock_vec=0.
REQ-033 Host write addr 2, data 0x1234, h_lock=1; then host write addr 2, data 0xFFFF -> second write gets h_err=1, reg stays 0x1234, lock_vec[2]=1.
REQ-034 h_req and d_req raised in the same cycle twice in a row -> grant order host, debug, and pointer alternates correctly.
REQ-035 Debug write to locked addr 2, data 0xBEEF, trusted=1, debug_mode=1 -> with DEBUG_OVERRIDE_EN: reg=0xBEEF, d_err=0; without it: d_err=1, reg unchanged.
REQ-036 Debug request with trusted=0, or with trusted dropping before COMMIT -> d_err=1; Reset pulsed during GRANT -> no ack, all registers and lock_vec read 0.
